// File: rtl/prefix_pkg.sv
// Shared types and elaboration helpers for the pipelined prefix adder.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package prefix_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

    function automatic int lat_f(input int levels, input int stage_levels);
        return 1 + (levels + stage_levels - 1) / stage_levels;
    endfunction

    // Index of the last prefix level evaluated inside stage group grp.
    function automatic int grp_end_f(input int grp, input int levels, input int stage_levels);
        int e;
        e = (grp + 1) * stage_levels;
        if (e > levels) e = levels;
        return e - 1;
    endfunction

endpackage

// File: rtl/pg_cell.sv
// Kogge-Stone (g,p) combine of a high span with the adjacent lower span.
// Latency: combinational.
// Backpressure: none.
module pg_cell
    import prefix_pkg::*;
(
    input  pg_t hi,
    input  pg_t lo,
    output pg_t o
);

    assign o.g = hi.g | (hi.p & lo.g);
    assign o.p = hi.p & lo.p;

endmodule

// File: rtl/pipelined_prefix_adder.sv
// WIDTH-bit Kogge-Stone add/sub, registered every STAGE_LEVELS prefix levels.
// Latency: 1 + ceil(LEVELS/STAGE_LEVELS) cycles, one beat per cycle.
// Backpressure: global stall while out_valid && !out_ready; all stages hold.
module pipelined_prefix_adder
    import prefix_pkg::*;
#(
    parameter int LEVELS       = 3,
    parameter int WIDTH        = 2 ** LEVELS,
    parameter int STAGE_LEVELS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NGRP = lat_f(LEVELS, STAGE_LEVELS) - 1;

    if (LEVELS < 1 || WIDTH != 2 ** LEVELS || STAGE_LEVELS < 1 || STAGE_LEVELS > LEVELS) begin : g_bad_params
        $error("pipelined_prefix_adder: need LEVELS>=1, WIDTH==2**LEVELS, 1<=STAGE_LEVELS<=LEVELS");
    end

    logic stall;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    logic [WIDTH-1:0] yy, g0, p0;
    logic             c0_in;
    pg_t [WIDTH-1:0]  pg_in;

    assign yy    = sub ? ~y : y;
    assign c0_in = sub | carry_in;
    assign g0    = x & yy;
    assign p0    = x ^ yy;

    // The carry-in acts as generate bit -1; folding it into bit 0 lets every
    // group generate G[i] from the tree be the true carry out of bit i.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            pg_in[i].g = g0[i];
            pg_in[i].p = p0[i];
        end
        pg_in[0].g = g0[0] | (p0[0] & c0_in);
    end

    pg_t [WIDTH-1:0]  st_pg  [NGRP];
    logic [WIDTH-1:0] st_po  [NGRP];
    logic [NGRP-1:0]  st_c0;
    logic [NGRP-1:0]  st_vld;

    pg_t [WIDTH-1:0]  lvl_in  [LEVELS];
    pg_t [WIDTH-1:0]  lvl_out [LEVELS];

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int D = 1 << k;
        if (k % STAGE_LEVELS == 0) begin : g_from_reg
            assign lvl_in[k] = st_pg[k / STAGE_LEVELS];
        end else begin : g_from_comb
            assign lvl_in[k] = lvl_out[k-1];
        end
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= D) begin : g_cell
                pg_cell u_cell (
                    .hi (lvl_in[k][i]),
                    .lo (lvl_in[k][i-D]),
                    .o  (lvl_out[k][i])
                );
            end else begin : g_pass
                assign lvl_out[k][i] = lvl_in[k][i];
            end
        end
    end

    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] z_nxt;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) carry[i] = lvl_out[LEVELS-1][i].g;
        z_nxt = st_po[NGRP-1] ^ {carry[WIDTH-2:0], st_c0[NGRP-1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NGRP; s++) begin
                st_pg[s] <= '0;
                st_po[s] <= '0;
            end
            st_c0     <= '0;
            st_vld    <= '0;
            out_valid <= 1'b0;
            z         <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (!stall) begin
            st_pg[0]  <= pg_in;
            st_po[0]  <= p0;
            st_c0[0]  <= c0_in;
            st_vld[0] <= in_valid;
            for (int s = 1; s < NGRP; s++) begin
                st_pg[s]  <= lvl_out[grp_end_f(s - 1, LEVELS, STAGE_LEVELS)];
                st_po[s]  <= st_po[s-1];
                st_c0[s]  <= st_c0[s-1];
                st_vld[s] <= st_vld[s-1];
            end
            out_valid <= st_vld[NGRP-1];
            z         <= z_nxt;
            carry_out <= carry[WIDTH-1];
            overflow  <= carry[WIDTH-1] ^ carry[WIDTH-2];
        end
    end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Scoreboard bench: instance a (STAGE_LEVELS=1, LAT=4) and b (STAGE_LEVELS=3, LAT=2).
module tb_pipelined_prefix_adder;

    localparam int LAT_A = 4;
    localparam int LAT_B = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       a_in_valid, a_in_ready, a_carry_in, a_sub, a_out_valid, a_out_ready, a_cout, a_ovf;
    logic [7:0] a_x, a_y, a_z;
    logic       b_in_valid, b_in_ready, b_carry_in, b_sub, b_out_valid, b_out_ready, b_cout, b_ovf;
    logic [7:0] b_x, b_y, b_z;

    pipelined_prefix_adder #(.LEVELS(3), .WIDTH(8), .STAGE_LEVELS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .x(a_x), .y(a_y), .carry_in(a_carry_in), .sub(a_sub),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .z(a_z), .carry_out(a_cout), .overflow(a_ovf)
    );

    pipelined_prefix_adder #(.LEVELS(3), .WIDTH(8), .STAGE_LEVELS(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .x(b_x), .y(b_y), .carry_in(b_carry_in), .sub(b_sub),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .z(b_z), .carry_out(b_cout), .overflow(b_ovf)
    );

    typedef struct {
        logic [7:0] z;
        logic       co;
        logic       ov;
        int         cyc;
        bit         chk_lat;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ma, mb;
    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    // Reference: plain integer add of x, (y or ~y) and the carry.
    function automatic exp_t model(input logic [7:0] xv, input logic [7:0] yv, input logic ci, input logic sb);
        exp_t r;
        logic [7:0] yyv;
        logic [8:0] s;
        yyv = sb ? ~yv : yv;
        s = {1'b0, xv} + {1'b0, yyv} + {8'd0, (sb ? 1'b1 : ci)};
        r.z = s[7:0];
        r.co = s[8];
        r.ov = (xv[7] == yyv[7]) && (s[7] != xv[7]);
        r.cyc = 0;
        r.chk_lat = 1'b0;
        return r;
    endfunction

    always @(negedge clk) begin
        #1;
        if (rst_n && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_extra_result: got z=%0h, required no result", a_z);
            end else begin
                ma = qa.pop_front();
                chk("a_z", {24'd0, a_z}, {24'd0, ma.z});
                chk("a_carry_out", {31'd0, a_cout}, {31'd0, ma.co});
                chk("a_overflow", {31'd0, a_ovf}, {31'd0, ma.ov});
                if (ma.chk_lat) chk("a_latency", cyc - ma.cyc, LAT_A);
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (rst_n && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_extra_result: got z=%0h, required no result", b_z);
            end else begin
                mb = qb.pop_front();
                chk("b_z", {24'd0, b_z}, {24'd0, mb.z});
                chk("b_carry_out", {31'd0, b_cout}, {31'd0, mb.co});
                chk("b_overflow", {31'd0, b_ovf}, {31'd0, mb.ov});
                if (mb.chk_lat) chk("b_latency", cyc - mb.cyc, LAT_B);
            end
        end
    end

    task automatic send(input int d, input logic [7:0] xv, input logic [7:0] yv, input logic ci,
                        input logic sb, input logic [7:0] ez, input logic eco, input logic eov,
                        input bit lat);
        exp_t e;
        int n;
        @(negedge clk);
        if (d == 0) begin
            a_in_valid = 1'b1; a_x = xv; a_y = yv; a_carry_in = ci; a_sub = sb;
        end else begin
            b_in_valid = 1'b1; b_x = xv; b_y = yv; b_carry_in = ci; b_sub = sb;
        end
        #1;
        n = 0;
        while (!(d == 0 ? a_in_ready : b_in_ready)) begin
            @(negedge clk);
            #1;
            n++;
            if (n > 50) begin
                checks++; errors++;
                $display("FAIL send_timeout: in_ready stuck at 0, required 1");
                return;
            end
        end
        e.z = ez; e.co = eco; e.ov = eov; e.cyc = cyc; e.chk_lat = lat;
        if (d == 0) qa.push_back(e);
        else qb.push_back(e);
        @(posedge clk);
    endtask

    task automatic sendm(input int d, input logic [7:0] xv, input logic [7:0] yv, input logic ci,
                         input logic sb, input bit lat);
        exp_t e;
        e = model(xv, yv, ci, sb);
        send(d, xv, yv, ci, sb, e.z, e.co, e.ov, lat);
    endtask

    task automatic idle();
        @(negedge clk);
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while ((d == 0 ? qa.size() : qb.size()) > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk(d == 0 ? "a_drain_pending" : "b_drain_pending", d == 0 ? qa.size() : qb.size(), 0);
    endtask

    task automatic reset_midstream(input int d, input int nbeats);
        for (int i = 0; i < nbeats; i++) sendm(d, 8'(8'h11 * (i + 1)), 8'h22, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        chk("rst_pre_out_valid", {31'd0, (d == 0 ? a_out_valid : b_out_valid)}, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, (d == 0 ? a_out_valid : b_out_valid)}, 0);
        chk("rst_z", {24'd0, (d == 0 ? a_z : b_z)}, 0);
        chk("rst_carry_out", {31'd0, (d == 0 ? a_cout : b_cout)}, 0);
        qa.delete();
        qb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(d, 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);
        idle();
        drain(d);
    endtask

    initial begin
        logic [7:0] rx, ry;
        logic [7:0] held;
        int n;
        a_in_valid = 0; a_x = 0; a_y = 0; a_carry_in = 0; a_sub = 0; a_out_ready = 1;
        b_in_valid = 0; b_x = 0; b_y = 0; b_carry_in = 0; b_sub = 0; b_out_ready = 1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_a_out_valid", {31'd0, a_out_valid}, 0);
        chk("reset_a_z", {24'd0, a_z}, 0);
        chk("reset_a_carry_out", {31'd0, a_cout}, 0);
        chk("reset_a_overflow", {31'd0, a_ovf}, 0);
        chk("reset_a_in_ready", {31'd0, a_in_ready}, 1);
        chk("reset_b_out_valid", {31'd0, b_out_valid}, 0);
        rst_n = 1'b1;

        // Hand-computed directed vectors, back to back.
        send(0, 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b1);
        send(0, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        send(0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
        send(0, 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1);
        send(0, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b1);
        send(0, 8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1);
        send(0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        send(0, 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        idle();
        drain(0);

        for (int i = 0; i < 16; i++) begin
            rx = 8'($urandom_range(255));
            ry = 8'($urandom_range(255));
            sendm(0, rx, ry, 1'(i % 3 == 0), 1'(i % 2), 1'b1);
        end
        idle();
        drain(0);

        fork
            begin
                for (int i = 0; i < 6; i++) sendm(0, 8'(8'h30 + i * 7), 8'(8'h41 - i), 1'b1, 1'(i % 2), 1'b0);
                idle();
            end
            begin
                n = 0;
                @(negedge clk);
                while (!a_out_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                a_out_ready = 1'b0;
                #1;
                held = a_z;
                chk("stall_in_ready", {31'd0, a_in_ready}, 0);
                repeat (2) begin
                    @(negedge clk);
                    #1;
                    chk("stall_in_ready", {31'd0, a_in_ready}, 0);
                    chk("stall_out_valid", {31'd0, a_out_valid}, 1);
                    chk("stall_z_hold", {24'd0, a_z}, {24'd0, held});
                end
                @(negedge clk);
                a_out_ready = 1'b1;
            end
        join
        drain(0);

        reset_midstream(0, 5);

        send(1, 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b1);
        send(1, 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b1);
        send(1, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
        idle();
        drain(1);

        reset_midstream(1, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
